// File: rtl/spi_host_ctrl.sv
// SPI host sequencer: serialises one register write/read request into a
// {w_nr, addr, pad, data} frame on the SPI pins and returns one response.
module spi_host_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 3,
  parameter int CMD_WIDTH  = 8,
  parameter int CLK_DIV    = 2,
  parameter int CS_GAP     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_wnr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  spi_clk,
  output logic                  spi_sel,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);
  localparam int FRAME = CMD_WIDTH + DATA_WIDTH;
  localparam int HW    = $clog2(CLK_DIV) + 1;
  localparam int BW    = $clog2(FRAME) + 1;
  localparam int GW    = $clog2(CS_GAP + 1) + 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

  state_e                state_q, state_d;
  logic [HW-1:0]         hcnt_q, hcnt_d;
  logic [BW-1:0]         bcnt_q, bcnt_d;
  logic [GW-1:0]         gcnt_q, gcnt_d;
  logic                  phase_q, phase_d;  // 1 = high half of the current spi_clk period
  logic [FRAME-1:0]      sh_q, sh_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic                  wnr_q, wnr_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [FRAME-1:0]      frame;
  logic                  half_done;

  always_comb begin
    frame                        = '0;
    frame[FRAME-1]               = req_wnr;
    frame[FRAME-2 -: ADDR_WIDTH] = req_addr;
    if (req_wnr) frame[DATA_WIDTH-1:0] = req_wdata;
  end

  assign half_done = (hcnt_q == HW'(CLK_DIV - 1));

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    bcnt_d      = bcnt_q;
    gcnt_d      = gcnt_q;
    phase_d     = phase_q;
    sh_d        = sh_q;
    rx_d        = rx_q;
    wnr_d       = wnr_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = SETUP;
          sh_d    = frame;
          wnr_d   = req_wnr;
          hcnt_d  = '0;
          rx_d    = '0;
        end
      end
      SETUP: begin
        if (half_done) begin
          state_d = SHIFT;
          hcnt_d  = '0;
          bcnt_d  = '0;
          phase_d = 1'b1;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      SHIFT: begin
        // First low cycle of a data period: device has driven miso since the rise.
        if (!phase_q && hcnt_q == '0 && bcnt_q >= BW'(CMD_WIDTH))
          rx_d = (rx_q << 1) | DATA_WIDTH'(spi_miso);
        if (half_done) begin
          hcnt_d  = '0;
          phase_d = !phase_q;
          if (!phase_q) begin
            // The last bit is held through HOLD; the register is cleared on exit.
            if (bcnt_q == BW'(FRAME - 1)) begin
              state_d = HOLD;
            end else begin
              bcnt_d = bcnt_q + BW'(1);
              sh_d   = sh_q << 1;
            end
          end
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      HOLD: begin
        if (half_done) begin
          hcnt_d      = '0;
          gcnt_d      = '0;
          sh_d        = '0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = wnr_q ? '0 : rx_q;
          state_d     = (CS_GAP == 0) ? IDLE : GAP;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      GAP: begin
        if (gcnt_q == GW'(CS_GAP - 1)) state_d = IDLE;
        else                           gcnt_d  = gcnt_q + GW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hcnt_q      <= '0;
      bcnt_q      <= '0;
      gcnt_q      <= '0;
      phase_q     <= 1'b0;
      sh_q        <= '0;
      rx_q        <= '0;
      wnr_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      bcnt_q      <= bcnt_d;
      gcnt_q      <= gcnt_d;
      phase_q     <= phase_d;
      sh_q        <= sh_d;
      rx_q        <= rx_d;
      wnr_q       <= wnr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign spi_sel   = !(state_q inside {SETUP, SHIFT, HOLD});
  assign spi_clk   = (state_q == SHIFT) && phase_q;
  assign spi_mosi  = sh_q[FRAME-1];
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_spi_host_ctrl.sv
// Bench for spi_host_ctrl: default instance against a behavioural SPI register
// device, plus a CLK_DIV=1 / CS_GAP=0 instance for back-to-back framing.
module tb_spi_host_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0, req_wnr = 1'b0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic       req_ready, rsp_valid, busy, spi_clk, spi_sel, spi_mosi;
  logic [7:0] rsp_rdata;
  logic       spi_miso = 1'b0;

  logic       f_req_valid = 1'b0, f_req_wnr = 1'b0;
  logic [2:0] f_req_addr = '0;
  logic [7:0] f_req_wdata = '0;
  logic       f_req_ready, f_rsp_valid, f_busy, f_spi_clk, f_spi_sel, f_spi_mosi;
  logic [7:0] f_rsp_rdata;

  always #5 clk = ~clk;

  spi_host_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .CMD_WIDTH(8), .CLK_DIV(2), .CS_GAP(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_wnr(req_wnr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
    .spi_clk(spi_clk), .spi_sel(spi_sel), .spi_mosi(spi_mosi), .spi_miso(spi_miso));

  spi_host_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .CMD_WIDTH(8), .CLK_DIV(1), .CS_GAP(0)) u_fast (
    .clk(clk), .rst_n(rst_n), .req_valid(f_req_valid), .req_ready(f_req_ready),
    .req_wnr(f_req_wnr), .req_addr(f_req_addr), .req_wdata(f_req_wdata),
    .rsp_valid(f_rsp_valid), .rsp_rdata(f_rsp_rdata), .busy(f_busy),
    .spi_clk(f_spi_clk), .spi_sel(f_spi_sel), .spi_mosi(f_spi_mosi), .spi_miso(1'b0));

  int n_checks = 0, n_fail = 0, cyc = 0, viol = 0;
  bit mon_en = 1'b0;

  logic [7:0] exp_q[$];
  int         acc_q[$];
  logic [7:0] model_regs [8] = '{default: 8'h00};

  // Behavioural SPI register device: samples mosi on spi_clk fall, drives miso after rise.
  logic [7:0]  dev_regs [8] = '{default: 8'h00};
  logic [15:0] dev_sh = '0;
  logic [7:0]  dev_cmd = '0;
  int          dev_n = 0;
  logic        dev_pclk = 1'b0, dev_psel = 1'b1;
  bit          rise_bits[$];
  initial forever begin
    @(negedge clk);
    if (spi_sel) begin
      if (!dev_psel && dev_n == 16 && dev_cmd[7]) dev_regs[dev_cmd[6:4]] = dev_sh[7:0];
      dev_n    = 0;
      spi_miso = 1'b0;
    end else begin
      if (spi_clk && !dev_pclk) begin
        logic [7:0] rd;
        rise_bits.push_back(spi_mosi);
        rd = dev_regs[dev_cmd[6:4]];
        if (dev_n >= 8 && !dev_cmd[7]) spi_miso = rd[15-dev_n];
      end
      if (!spi_clk && dev_pclk) begin
        dev_sh = {dev_sh[14:0], spi_mosi};
        if (dev_n == 7) dev_cmd = dev_sh[7:0];
        dev_n++;
      end
    end
    dev_pclk = spi_clk;
    dev_psel = spi_sel;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Main-instance monitor: chip-select timing, scoreboard and invariants.
  int   low_run = 0, high_run = 0, low_len = 0, high_len = 0, last_rise = 0;
  logic m_psel = 1'b1, m_prsp = 1'b0;
  initial forever begin
    @(negedge clk);
    if (!spi_sel) begin
      if (m_psel) high_len = high_run;
      low_run++;
      high_run = 0;
    end else begin
      if (!m_psel) begin low_len = low_run; last_rise = cyc; end
      low_run = 0;
      high_run++;
    end
    m_psel = spi_sel;
    if (mon_en) begin
      if (rst_n && req_valid && req_ready) acc_q.push_back(cyc);
      n_checks++;
      if (spi_sel && spi_clk) begin
        n_fail++; viol++;
        if (viol < 5) $display("FAIL clk_while_deselected: spi_clk=%b spi_sel=%b want spi_clk=0 at cyc %0d", spi_clk, spi_sel, cyc);
      end
      n_checks++;
      if (rsp_valid && req_valid && req_ready) begin
        n_fail++; viol++;
        if (viol < 5) $display("FAIL rsp_overlaps_accept: rsp_valid=1 with acceptance at cyc %0d, want no overlap", cyc);
      end
      if (rsp_valid) begin
        n_checks++;
        if (m_prsp) begin
          n_fail++;
          $display("FAIL rsp_pulse_width: rsp_valid high in consecutive cycles at cyc %0d, want single pulse", cyc);
        end
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: rsp_valid with rdata=%h at cyc %0d, want no response", rsp_rdata, cyc);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (rsp_rdata !== e) begin
            n_fail++;
            $display("FAIL rsp_rdata: got %h want %h", rsp_rdata, e);
          end
        end
        if (acc_q.size() != 0) begin
          int a;
          a = acc_q.pop_front();
          n_checks++;
          if (cyc - a != 69) begin
            n_fail++;
            $display("FAIL rsp_latency: got %0d cycles want 69", cyc - a);
          end
        end
      end
    end
    m_prsp = rsp_valid;
  end

  // Fast-instance monitor.
  int   f_low_run = 0, f_low_len = 0, f_rsp_cnt = 0;
  int   f_acc_q[$], f_rise_q[$];
  logic f_psel = 1'b1;
  logic [7:0] f_last_rdata = '0;
  initial forever begin
    @(negedge clk);
    if (!f_spi_sel) f_low_run++;
    else begin
      if (!f_psel) begin f_low_len = f_low_run; f_rise_q.push_back(cyc); end
      f_low_run = 0;
    end
    f_psel = f_spi_sel;
    if (mon_en) begin
      if (rst_n && f_req_valid && f_req_ready) f_acc_q.push_back(cyc);
      if (f_rsp_valid) begin f_rsp_cnt++; f_last_rdata = f_rsp_rdata; end
      n_checks++;
      if (f_spi_sel && f_spi_clk) begin
        n_fail++; viol++;
        if (viol < 5) $display("FAIL fast_clk_while_deselected: spi_clk=%b spi_sel=%b want spi_clk=0 at cyc %0d", f_spi_clk, f_spi_sel, cyc);
      end
    end
  end

  task automatic send(input logic wnr, input logic [2:0] addr, input logic [7:0] data, input bit expect_rsp);
    int t;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wnr = wnr; req_addr = addr; req_wdata = data;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready && t < 300);
    if (!req_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send_accept_timeout: req_ready=%b after %0d cycles want 1", req_ready, t);
    end else if (expect_rsp) begin
      exp_q.push_back(wnr ? 8'h00 : model_regs[addr]);
      if (wnr) model_regs[addr] = data;
    end
    @(posedge clk); #1 req_valid = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) begin
      n_checks++; n_fail++;
      $display("FAIL frame_timeout: %0d responses outstanding busy=%b want 0", exp_q.size(), busy);
    end
    repeat (3) @(negedge clk);
  endtask

  function automatic logic [15:0] rise_word(input int base);
    logic [15:0] w = '0;
    for (int i = 0; i < 16; i++) w[15-i] = rise_bits[base+i];
    return w;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_wnr = 1'b1; req_addr = 3'd1; req_wdata = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (spi_sel !== 1'b1)   begin n_fail++; $display("FAIL reset_sel: got %b want 1", spi_sel); end
    n_checks++; if (spi_clk !== 1'b0)   begin n_fail++; $display("FAIL reset_clk: got %b want 0", spi_clk); end
    n_checks++; if (spi_mosi !== 1'b0)  begin n_fail++; $display("FAIL reset_mosi: got %b want 0", spi_mosi); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
    n_checks++; if (rsp_rdata !== 8'h00) begin n_fail++; $display("FAIL reset_rsp_rdata: got %h want 00", rsp_rdata); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    @(posedge clk); #1 req_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_ignored_req: busy=%b want 0", busy); end
    mon_en = 1'b1;
  endtask

  task automatic test_write();
    rise_bits.delete();
    send(1'b1, 3'b111, 8'h6A, 1'b1);
    wait_done();
    n_checks++;
    if (rise_bits.size() != 16) begin
      n_fail++; $display("FAIL write_rise_count: got %0d want 16", rise_bits.size());
    end else if (rise_word(0) !== 16'hF06A) begin
      n_fail++; $display("FAIL write_mosi_bits: got %h want f06a", rise_word(0));
    end
    n_checks++; if (low_len != 68) begin n_fail++; $display("FAIL write_sel_low: got %0d want 68", low_len); end
    n_checks++; if (dev_regs[7] !== 8'h6A) begin n_fail++; $display("FAIL write_device_reg: got %h want 6a", dev_regs[7]); end
  endtask

  task automatic test_read();
    send(1'b1, 3'b010, 8'hA5, 1'b1);
    wait_done();
    rise_bits.delete();
    send(1'b0, 3'b010, 8'hFF, 1'b1);
    wait_done();
    n_checks++;
    if (rise_bits.size() != 16) begin
      n_fail++; $display("FAIL read_rise_count: got %0d want 16", rise_bits.size());
    end else if (rise_word(0) !== 16'h2000) begin
      n_fail++; $display("FAIL read_mosi_bits: got %h want 2000", rise_word(0));
    end
    send(1'b0, 3'b111, 8'h00, 1'b1);
    wait_done();
  endtask

  task automatic test_back_to_back();
    int t, a1, a2, r1;
    rise_bits.delete();
    @(posedge clk); #1;
    req_valid = 1'b1; req_wnr = 1'b1; req_addr = 3'd3; req_wdata = 8'hC3;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready && t < 300);
    a1 = cyc;
    exp_q.push_back(8'h00); model_regs[3] = 8'hC3;
    @(posedge clk); #1 req_addr = 3'd4; req_wdata = 8'h3C;
    exp_q.push_back(8'h00); model_regs[4] = 8'h3C;
    t = 0;
    do begin @(negedge clk); t++; end while (!req_ready && t < 300);
    a2 = cyc; r1 = last_rise;
    @(posedge clk); #1 req_valid = 1'b0;
    n_checks++; if (a2 - r1 != 2)  begin n_fail++; $display("FAIL b2b_accept_after_rise: got %0d want 2", a2 - r1); end
    n_checks++; if (a2 - a1 != 71) begin n_fail++; $display("FAIL b2b_accept_spacing: got %0d want 71", a2 - a1); end
    wait_done();
    n_checks++; if (high_len != 3) begin n_fail++; $display("FAIL b2b_sel_high: got %0d want 3", high_len); end
    n_checks++;
    if (rise_bits.size() != 32) begin
      n_fail++; $display("FAIL b2b_rise_count: got %0d want 32", rise_bits.size());
    end else if (rise_word(0) !== 16'hB0C3) begin
      n_fail++; $display("FAIL b2b_first_frame: got %h want b0c3", rise_word(0));
    end
    n_checks++; if (dev_regs[3] !== 8'hC3) begin n_fail++; $display("FAIL b2b_reg3: got %h want c3", dev_regs[3]); end
    n_checks++; if (dev_regs[4] !== 8'h3C) begin n_fail++; $display("FAIL b2b_reg4: got %h want 3c", dev_regs[4]); end
  endtask

  task automatic test_reset_mid();
    int t = 0;
    rise_bits.delete();
    send(1'b1, 3'd6, 8'hFF, 1'b0);
    while (rise_bits.size() < 6 && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin n_checks++; n_fail++; $display("FAIL mid_reset_wait: rises=%0d want 6", rise_bits.size()); end
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    n_checks++; if (spi_sel !== 1'b1)   begin n_fail++; $display("FAIL mid_reset_sel: got %b want 1", spi_sel); end
    n_checks++; if (spi_clk !== 1'b0)   begin n_fail++; $display("FAIL mid_reset_clk: got %b want 0", spi_clk); end
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("FAIL mid_reset_busy: got %b want 0", busy); end
    n_checks++; if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_rsp: got %b want 0", rsp_valid); end
    acc_q.delete();
    repeat (80) @(negedge clk);
    n_checks++; if (dev_regs[6] !== 8'h00) begin n_fail++; $display("FAIL mid_reset_aborted_write: got %h want 00", dev_regs[6]); end
    send(1'b1, 3'd5, 8'h5A, 1'b1);
    wait_done();
    n_checks++; if (dev_regs[5] !== 8'h5A) begin n_fail++; $display("FAIL mid_reset_recovery: got %h want 5a", dev_regs[5]); end
  endtask

  task automatic test_fast();
    int t = 0;
    f_acc_q.delete(); f_rise_q.delete(); f_rsp_cnt = 0;
    @(posedge clk); #1;
    f_req_valid = 1'b1; f_req_wnr = 1'b1; f_req_addr = 3'd1; f_req_wdata = 8'h55;
    while (f_acc_q.size() < 2 && t < 200) begin @(negedge clk); t++; end
    @(posedge clk); #1 f_req_valid = 1'b0;
    t = 0;
    while (f_rsp_cnt < 2 && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    n_checks++;
    if (f_acc_q.size() != 2 || f_rise_q.size() < 1) begin
      n_fail++; $display("FAIL fast_accepts: got %0d accepts %0d rises want 2 and >=1", f_acc_q.size(), f_rise_q.size());
    end else begin
      if (f_acc_q[1] - f_acc_q[0] != 35) begin n_fail++; $display("FAIL fast_spacing: got %0d want 35", f_acc_q[1] - f_acc_q[0]); end
      n_checks++;
      if (f_acc_q[1] != f_rise_q[0]) begin n_fail++; $display("FAIL fast_accept_at_rise: got %0d want %0d", f_acc_q[1], f_rise_q[0]); end
    end
    n_checks++; if (f_low_len != 34)      begin n_fail++; $display("FAIL fast_sel_low: got %0d want 34", f_low_len); end
    n_checks++; if (f_rsp_cnt != 2)       begin n_fail++; $display("FAIL fast_rsp_count: got %0d want 2", f_rsp_cnt); end
    n_checks++; if (f_last_rdata !== 8'h00) begin n_fail++; $display("FAIL fast_rsp_rdata: got %h want 00", f_last_rdata); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_back_to_back();
    test_reset_mid();
    test_fast();
    repeat (5) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin n_fail++; $display("FAIL leftover_responses: got %0d want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
